drive_supervisor: RTL and testbench
===================================

DRIVE_SUPERVISOR -- requirements
Module: drive_supervisor

Interface
REQ-001 Parameter N_CPU, default 4: number of independent CPU thermal channels, legal range 1..32.
REQ-002 Parameter DEBOUNCE, default 3: consecutive overheated samples required before a channel shuts off, legal range 1..255.
REQ-003 Parameter COOLDOWN, default 8: consecutive cool samples required before a shut-off channel restarts, legal range 1..255.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_overheated  in  N_CPU  per-channel overheat flag, bit i = channel i.
REQ-007 arrived  in  1  destination reached.
REQ-008 gas_tank_empty  in  1  fuel exhausted.
REQ-009 start  in  1  single-cycle or level request to begin driving.
REQ-010 shut_off_computer  out  N_CPU  per-channel computer shut-off, registered.
REQ-011 keep_driving  out  1  vehicle commanded to keep driving.
REQ-012 all_computers_off  out  1  AND-reduction of shut_off_computer.
REQ-013 state  out  2  current FSM state encoding.

Function
REQ-014 Each channel SHALL keep an 8-bit debounce counter and an 8-bit cooldown counter, both saturating and never wrapping.
REQ-015 A channel not shut off SHALL increment its debounce counter on each edge with overheated=1 and clear it on each edge with overheated=0.
REQ-016 shut_off_computer[i] SHALL assert on the edge that samples the DEBOUNCE-th consecutive overheated=1; with DEBOUNCE=1 this is a one-cycle registered follow.
REQ-017 On assertion, the cooldown counter SHALL load COOLDOWN and the debounce counter SHALL clear.
REQ-018 While shut off, overheated=1 SHALL reload the cooldown counter with COOLDOWN, and overheated=0 SHALL decrement it.
REQ-019 shut_off_computer[i] SHALL deassert on the edge that samples overheated=0 with cooldown counter = 1, i.e. after exactly COOLDOWN consecutive cool samples.
REQ-020 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-021 The FSM states SHALL be PARKED=0, DRIVING=1, OUT_OF_GAS=2, ARRIVED=3.
REQ-022 From PARKED: start=1 and gas_tank_empty=0 SHALL go to DRIVING; start=1 with gas_tank_empty=1 SHALL stay PARKED.
REQ-023 From DRIVING, transitions SHALL follow this priority: gas_tank_empty=1 to OUT_OF_GAS; else arrived=1 to ARRIVED; else all_computers_off=1 to PARKED; else stay.
REQ-024 From OUT_OF_GAS: gas_tank_empty=0 SHALL go to PARKED.
REQ-025 From ARRIVED: arrived=0 SHALL go to PARKED.
REQ-026 keep_driving SHALL be combinational: (state==DRIVING) AND NOT arrived AND NOT gas_tank_empty AND NOT all_computers_off, so it drops in the same cycle as the cause.
REQ-027 start SHALL be ignored in every state except PARKED.
REQ-028 all_computers_off SHALL be combinational from the registered shut_off_computer.

Reset
REQ-029 With reset=1 at an edge, the following SHALL hold after that edge: state=PARKED, shut_off_computer=0, all counters=0, keep_driving=0, all_computers_off=0.
REQ-030 Reset SHALL take priority over all other inputs, including mid-debounce and mid-cooldown.
REQ-031 No output SHALL depend on reset asynchronously.

Structure
REQ-032 The package drive_supervisor_pkg SHALL hold the state enum and encodings, the counter width constant (8), and the parameter legality limits.
REQ-033 The per-channel debounce/cooldown logic SHALL be the sub-module overheat_filter, instantiated N_CPU times.
REQ-034 The FSM and output logic SHALL reside in drive_supervisor.

Verification (N_CPU=4, DEBOUNCE=3, COOLDOWN=8)
REQ-035 Overheat ch0 high 2 edges then low -> shut_off_computer stays 4'b0000. Ch0 high 3 edges -> bit0=1 after the 3rd edge.
REQ-036 Ch0 shut off, overheat low 7 edges, high 1 edge, low 8 edges -> bit0 stays 1 until the 8th low edge, then 0.
REQ-037 PARKED, start=1, gas_tank_empty=0 -> state=1 and keep_driving=1. Then arrived=1 -> keep_driving=0 same cycle, state=3 next edge. Then arrived=0 -> state=0.
REQ-038 DRIVING with gas_tank_empty=1 and arrived=1 on the same edge -> state=2. Then gas_tank_empty=0 -> state=0.
REQ-039 DRIVING with all four channels overheated 3 edges -> all_computers_off=1 and keep_driving=0, state=0 next edge. Random 200-cycle traffic checked against a reference model.
REQ-040 reset=1 mid-cooldown while in DRIVING -> all outputs 0 and state=0 after the edge. start is ignored while reset=1.

Source files
------------

// File: rtl/drive_supervisor_pkg.sv
// Shared types and constants for the drive supervisor: FSM encoding, counter width,
// parameter legality limits and a couple of small counter helpers.
package drive_supervisor_pkg;

  localparam int CNT_W = 8;

  localparam int N_CPU_MIN    = 1;
  localparam int N_CPU_MAX    = 32;
  localparam int DEBOUNCE_MIN = 1;
  localparam int DEBOUNCE_MAX = 255;
  localparam int COOLDOWN_MIN = 1;
  localparam int COOLDOWN_MAX = 255;

  typedef enum logic [1:0] {
    PARKED     = 2'd0,
    DRIVING    = 2'd1,
    OUT_OF_GAS = 2'd2,
    ARRIVED    = 2'd3
  } state_e;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/drive_supervisor_if.sv
// Bundle of the supervisor's sensor inputs and command outputs.
interface drive_supervisor_if #(
  parameter int N_CPU = 4
) ();

  logic [N_CPU-1:0] cpu_overheated;
  logic             arrived;
  logic             gas_tank_empty;
  logic             start;
  logic [N_CPU-1:0] shut_off_computer;
  logic             keep_driving;
  logic             all_computers_off;
  logic [1:0]       state;

  modport master (
    output cpu_overheated, arrived, gas_tank_empty, start,
    input  shut_off_computer, keep_driving, all_computers_off, state
  );

  modport slave (
    input  cpu_overheated, arrived, gas_tank_empty, start,
    output shut_off_computer, keep_driving, all_computers_off, state
  );

endinterface

// File: rtl/overheat_filter.sv
// One CPU thermal channel: debounces the overheat flag into a registered shut-off
// and holds it until a run of cool samples has elapsed.
module overheat_filter
  import drive_supervisor_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int COOLDOWN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic overheated,
  output logic shut_off
);

  localparam cnt_t DEB_LAST  = cnt_t'(clamp(DEBOUNCE, DEBOUNCE_MIN, DEBOUNCE_MAX) - 1);
  localparam cnt_t COOL_LOAD = cnt_t'(clamp(COOLDOWN, COOLDOWN_MIN, COOLDOWN_MAX));

  cnt_t deb_q, deb_d;
  cnt_t cool_q, cool_d;
  logic shut_q, shut_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    deb_d  = deb_q;
    cool_d = cool_q;
    shut_d = shut_q;
    if (!shut_q) begin
      if (!overheated) begin
        deb_d = '0;
      end else if (deb_q >= DEB_LAST) begin
        shut_d = 1'b1;
        cool_d = COOL_LOAD;
        deb_d  = '0;
      end else begin
        deb_d = sat_inc(deb_q);
      end
    end else begin
      if (overheated) begin
        cool_d = COOL_LOAD;
      end else if (cool_q <= cnt_t'(1)) begin
        // Last cool sample of the run: release and park the counter at zero.
        shut_d = 1'b0;
        cool_d = '0;
      end else begin
        cool_d = cool_q - cnt_t'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q  <= '0;
      cool_q <= '0;
      shut_q <= 1'b0;
    end else begin
      deb_q  <= deb_d;
      cool_q <= cool_d;
      shut_q <= shut_d;
    end
  end

  assign shut_off = shut_q;

endmodule

// File: rtl/drive_supervisor.sv
// Vehicle drive supervisor: per-CPU thermal filters plus the driving-mode FSM that
// decides whether the vehicle keeps driving.
module drive_supervisor
  import drive_supervisor_pkg::*;
#(
  parameter int N_CPU    = 4,
  parameter int DEBOUNCE = 3,
  parameter int COOLDOWN = 8
) (
  input  logic               clk,
  input  logic               reset,
  drive_supervisor_if.slave  bus
);

  logic [N_CPU-1:0] shut;
  logic             all_off;
  state_e           state_q, state_d;

  for (genvar i = 0; i < N_CPU; i++) begin : g_ch
    overheat_filter #(
      .DEBOUNCE (DEBOUNCE),
      .COOLDOWN (COOLDOWN)
    ) u_filter (
      .clk        (clk),
      .reset      (reset),
      .overheated (bus.cpu_overheated[i]),
      .shut_off   (shut[i])
    );
  end

  assign all_off = &shut;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PARKED:     if (bus.start && !bus.gas_tank_empty) state_d = DRIVING;
      DRIVING: begin
        if (bus.gas_tank_empty)   state_d = OUT_OF_GAS;
        else if (bus.arrived)     state_d = ARRIVED;
        else if (all_off)         state_d = PARKED;
      end
      OUT_OF_GAS: if (!bus.gas_tank_empty) state_d = PARKED;
      ARRIVED:    if (!bus.arrived)        state_d = PARKED;
      default:    state_d = PARKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= PARKED;
    else       state_q <= state_d;
  end

  // keep_driving drops in the same cycle as its cause, ahead of the state change.
  assign bus.keep_driving      = (state_q == DRIVING) && !bus.arrived
                                 && !bus.gas_tank_empty && !all_off;
  assign bus.shut_off_computer = shut;
  assign bus.all_computers_off = all_off;
  assign bus.state             = state_q;

endmodule

// File: tb/tb_drive_supervisor.sv
// Scoreboard bench for drive_supervisor: directed scenarios and random traffic are
// checked against a streak-counting reference model of the supervisor's behaviour.
module tb_drive_supervisor;

  localparam int N   = 4;
  localparam int DEB = 3;
  localparam int COOL = 8;

  typedef struct {
    logic [1:0]   st;
    logic [N-1:0] shut;
    logic         all_off;
    logic         keep;
    string        tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  drive_supervisor_if #(.N_CPU(N)) bus ();

  drive_supervisor #(.N_CPU(N), .DEBOUNCE(DEB), .COOLDOWN(COOL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: mode 0..3 and, per channel, streak lengths of hot/cool samples.
  int m_state;
  bit m_off[N];
  int hot_run[N];
  int cool_run[N];

  function automatic bit m_all_off();
    for (int i = 0; i < N; i++) if (!m_off[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [N-1:0] m_shut();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_off[i];
    return v;
  endfunction

  task automatic m_reset();
    m_state = 0;
    for (int i = 0; i < N; i++) begin
      m_off[i] = 0; hot_run[i] = 0; cool_run[i] = 0;
    end
  endtask

  task automatic m_edge();
    bit all_off_now;
    if (reset) begin
      m_reset();
      return;
    end
    all_off_now = m_all_off();
    case (m_state)
      0: if (bus.start && !bus.gas_tank_empty) m_state = 1;
      1: if (bus.gas_tank_empty) m_state = 2;
         else if (bus.arrived)   m_state = 3;
         else if (all_off_now)   m_state = 0;
      2: if (!bus.gas_tank_empty) m_state = 0;
      default: if (!bus.arrived) m_state = 0;
    endcase
    for (int i = 0; i < N; i++) begin
      if (!m_off[i]) begin
        hot_run[i] = bus.cpu_overheated[i] ? hot_run[i] + 1 : 0;
        if (hot_run[i] == DEB) begin
          m_off[i] = 1; hot_run[i] = 0; cool_run[i] = 0;
        end
      end else begin
        cool_run[i] = bus.cpu_overheated[i] ? 0 : cool_run[i] + 1;
        if (cool_run[i] == COOL) begin
          m_off[i] = 0; cool_run[i] = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs for the coming edge and queue the outputs expected before that edge.
  task automatic drive(input logic [N-1:0] ovh, input logic arr, input logic gas,
                       input logic st, input logic rst, input string tag);
    exp_t e;
    bus.cpu_overheated = ovh;
    bus.arrived        = arr;
    bus.gas_tank_empty = gas;
    bus.start          = st;
    reset              = rst;
    e.st      = 2'(m_state);
    e.shut    = m_shut();
    e.all_off = m_all_off();
    e.keep    = (m_state == 1) && !arr && !gas && !m_all_off();
    e.tag     = tag;
    exp_q.push_back(e);
  endtask

  task automatic expect_const(input logic [1:0] st, input logic [N-1:0] shut,
                              input logic all_off, input logic keep, input string tag);
    exp_t e;
    e.st = st; e.shut = shut; e.all_off = all_off; e.keep = keep; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [N-1:0] ovh, input logic arr, input logic gas,
                      input logic st, input logic rst, input string tag);
    drive(ovh, arr, gas, st, rst, tag);
    tick();
  endtask

  // Monitor: outputs are stable at the falling edge; compare all queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".state"},    32'(bus.state),             32'(e.st));
        check({e.tag, ".shut"},     32'(bus.shut_off_computer), 32'(e.shut));
        check({e.tag, ".all_off"},  32'(bus.all_computers_off), 32'(e.all_off));
        check({e.tag, ".keep"},     32'(bus.keep_driving),      32'(e.keep));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cpu_overheated = '0;
    bus.arrived = 1'b0; bus.gas_tank_empty = 1'b0; bus.start = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;

    drive('0, 0, 0, 0, 0, "reset");
    expect_const(2'd0, 4'b0000, 1'b0, 1'b0, "reset_c");
    tick();

    // Debounce: two hot samples are not enough, three are.
    step(4'b0001, 0, 0, 0, 0, "deb");
    step(4'b0001, 0, 0, 0, 0, "deb");
    drive(4'b0000, 0, 0, 0, 0, "deb2");
    expect_const(2'd0, 4'b0000, 1'b0, 1'b0, "deb2_c");
    tick();
    for (int i = 0; i < 3; i++) step(4'b0001, 0, 0, 0, 0, "deb3");

    // Cooldown: 7 cool, 1 hot (restarts the run), then 8 cool to release.
    drive(4'b0000, 0, 0, 0, 0, "shut");
    expect_const(2'd0, 4'b0001, 1'b0, 1'b0, "shut_c");
    tick();
    for (int i = 0; i < 6; i++) step(4'b0000, 0, 0, 0, 0, "cool");
    step(4'b0001, 0, 0, 0, 0, "reheat");
    for (int i = 0; i < 7; i++) step(4'b0000, 0, 0, 0, 0, "cool");
    drive(4'b0000, 0, 0, 0, 0, "cool7");
    expect_const(2'd0, 4'b0001, 1'b0, 1'b0, "cool7_c");
    tick();
    drive(4'b0000, 0, 0, 0, 0, "cool8");
    expect_const(2'd0, 4'b0000, 1'b0, 1'b0, "cool8_c");
    tick();

    // Start, then arrival drops keep_driving combinationally.
    step('0, 0, 0, 1, 0, "start");
    drive('0, 0, 0, 0, 0, "driving");
    expect_const(2'd1, 4'b0000, 1'b0, 1'b1, "driving_c");
    tick();
    drive('0, 1, 0, 0, 0, "arr_same");
    expect_const(2'd1, 4'b0000, 1'b0, 1'b0, "arr_same_c");
    tick();
    drive('0, 0, 0, 1, 0, "arrived");
    expect_const(2'd3, 4'b0000, 1'b0, 1'b0, "arrived_c");
    tick();
    drive('0, 0, 0, 0, 0, "parked");
    expect_const(2'd0, 4'b0000, 1'b0, 1'b0, "parked_c");
    tick();

    // Fuel beats arrival when both are raised together.
    step('0, 0, 0, 1, 0, "start");
    step('0, 1, 1, 0, 0, "gas_arr");
    drive('0, 0, 0, 1, 0, "oog");
    expect_const(2'd2, 4'b0000, 1'b0, 1'b0, "oog_c");
    tick();
    drive('0, 0, 0, 0, 0, "refuel");
    expect_const(2'd0, 4'b0000, 1'b0, 1'b0, "refuel_c");
    tick();

    // Every computer shut off parks the vehicle.
    step('0, 0, 0, 1, 0, "start");
    drive(4'hf, 0, 0, 0, 0, "hot1");
    expect_const(2'd1, 4'b0000, 1'b0, 1'b1, "hot1_c");
    tick();
    step(4'hf, 0, 0, 0, 0, "hot");
    step(4'hf, 0, 0, 0, 0, "hot");
    drive(4'h0, 0, 0, 0, 0, "all_off");
    expect_const(2'd1, 4'b1111, 1'b1, 1'b0, "all_off_c");
    tick();
    drive(4'h0, 0, 0, 1, 0, "parked_off");
    expect_const(2'd0, 4'b1111, 1'b1, 1'b0, "parked_off_c");
    tick();

    // Reset mid-cooldown while driving; start held high during reset is ignored.
    step('0, 0, 0, 0, 1, "rst");
    step('0, 0, 0, 1, 0, "start");
    for (int i = 0; i < 3; i++) step(4'b0001, 0, 0, 0, 0, "hot_ch0");
    step(4'b0000, 0, 0, 0, 0, "cool_ch0");
    drive(4'b0000, 0, 0, 1, 1, "pre_rst");
    expect_const(2'd1, 4'b0001, 1'b0, 1'b1, "pre_rst_c");
    tick();
    drive(4'b0000, 0, 0, 0, 0, "rst_mid");
    expect_const(2'd0, 4'b0000, 1'b0, 1'b0, "rst_mid_c");
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 200; c++) begin
      step(N'($urandom & $urandom), ($urandom_range(7) == 0), ($urandom_range(9) == 0),
           ($urandom_range(3) == 0), ($urandom_range(63) == 0), "rand");
    end

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
